uart_echo_fifo: RTL

//  UART loopback/echo: every byte received on rx is retransmitted on tx.

---
 rtl/uart_echo_fifo.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_echo_fifo.sv
// UART echo: bytes received on rx are buffered in a FIFO and retransmitted on tx.
// RX and TX share one oversampling tick; i_echo_en pauses draining without stopping reception.
module uart_echo_fifo #(
   parameter  int CLK_HZ     = 100_000_000,
   parameter  int BAUD       = 9600,
   parameter  int OVERSAMPLE = 16,
   parameter  int DATA_BITS  = 8,
   parameter  int FIFO_DEPTH = 16,
   localparam int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rx,
   output logic          tx,
   input  logic          i_echo_en,
   output logic [AW:0]   o_fifo_count,
   output logic          o_overflow,
   output logic          o_frame_err,
   output logic          o_tx_busy
);

   localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);

   localparam logic [OW-1:0] SAMPLE_HALF = OW'(OVERSAMPLE / 2 - 1);
   localparam logic [OW-1:0] SAMPLE_LAST = OW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   logic [DW-1:0]        div_cnt;
   logic                 tick;
   logic                 rx_meta, rx_sync;

   rx_state_t            rx_state, rx_state_n;
   logic [OW-1:0]        rx_cnt, rx_cnt_n;
   logic [BW-1:0]        rx_bit, rx_bit_n;
   logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
   logic                 rx_push, frame_err_n;

   tx_state_t            tx_state, tx_state_n;
   logic [OW-1:0]        tx_cnt, tx_cnt_n;
   logic [BW-1:0]        tx_bit, tx_bit_n;
   logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
   logic                 tx_n, pop;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic                 full, push_ok;

   assign tick    = (div_cnt == DW'(DIV - 1));
   assign full    = (o_fifo_count == (AW+1)'(FIFO_DEPTH));
   assign push_ok = rx_push && !full;

   // Free-running baud divider and the rx synchroniser.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_comb begin
      rx_state_n  = rx_state;
      rx_cnt_n    = rx_cnt;
      rx_bit_n    = rx_bit;
      rx_shift_n  = rx_shift;
      rx_push     = 1'b0;
      frame_err_n = 1'b0;
      if (tick) begin
         case (rx_state)
            RX_IDLE: begin
               if (!rx_sync) begin
                  rx_state_n = RX_START;
                  rx_cnt_n   = '0;
               end
            end
            RX_START: begin
               if (rx_cnt == SAMPLE_HALF) begin
                  rx_cnt_n   = '0;
                  rx_bit_n   = '0;
                  rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_n = rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == SAMPLE_LAST) begin
                  rx_cnt_n   = '0;
                  rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
                  if (rx_bit == BIT_LAST) rx_state_n = RX_STOP;
                  else                    rx_bit_n   = rx_bit + 1'b1;
               end else begin
                  rx_cnt_n = rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == SAMPLE_LAST) begin
                  rx_cnt_n    = '0;
                  rx_state_n  = RX_IDLE;
                  rx_push     = rx_sync;
                  frame_err_n = !rx_sync;
               end else begin
                  rx_cnt_n = rx_cnt + 1'b1;
               end
            end
            default: rx_state_n = RX_IDLE;
         endcase
      end
   end

   // The transmitter only pops from IDLE, so a byte pushed this cycle leaves next cycle at the earliest.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      tx_n       = tx;
      pop        = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            tx_n = 1'b1;
            if (o_fifo_count != '0 && i_echo_en) begin
               pop        = 1'b1;
               tx_shift_n = mem[rd_ptr];
               tx_cnt_n   = '0;
               tx_state_n = TX_START;
               tx_n       = 1'b0;
            end
         end
         TX_START: begin
            if (tick) begin
               if (tx_cnt == SAMPLE_LAST) begin
                  tx_cnt_n   = '0;
                  tx_bit_n   = '0;
                  tx_state_n = TX_DATA;
                  tx_n       = tx_shift[0];
               end else begin
                  tx_cnt_n = tx_cnt + 1'b1;
               end
            end
         end
         TX_DATA: begin
            if (tick) begin
               if (tx_cnt == SAMPLE_LAST) begin
                  tx_cnt_n   = '0;
                  tx_shift_n = tx_shift >> 1;
                  if (tx_bit == BIT_LAST) begin
                     tx_state_n = TX_STOP;
                     tx_n       = 1'b1;
                  end else begin
                     tx_bit_n = tx_bit + 1'b1;
                     tx_n     = tx_shift[1];
                  end
               end else begin
                  tx_cnt_n = tx_cnt + 1'b1;
               end
            end
         end
         TX_STOP: begin
            if (tick) begin
               if (tx_cnt == SAMPLE_LAST) begin
                  tx_cnt_n   = '0;
                  tx_state_n = TX_IDLE;
               end else begin
                  tx_cnt_n = tx_cnt + 1'b1;
               end
            end
         end
         default: tx_state_n = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state     <= RX_IDLE;
         rx_cnt       <= '0;
         rx_bit       <= '0;
         rx_shift     <= '0;
         o_frame_err  <= 1'b0;
         tx_state     <= TX_IDLE;
         tx_cnt       <= '0;
         tx_bit       <= '0;
         tx_shift     <= '0;
         tx           <= 1'b1;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         o_fifo_count <= '0;
         o_overflow   <= 1'b0;
      end else begin
         rx_state    <= rx_state_n;
         rx_cnt      <= rx_cnt_n;
         rx_bit      <= rx_bit_n;
         rx_shift    <= rx_shift_n;
         o_frame_err <= frame_err_n;
         tx_state    <= tx_state_n;
         tx_cnt      <= tx_cnt_n;
         tx_bit      <= tx_bit_n;
         tx_shift    <= tx_shift_n;
         tx          <= tx_n;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (rx_push && full) o_overflow <= 1'b1;
         case ({push_ok, pop})
            2'b10:   o_fifo_count <= o_fifo_count + 1'b1;
            2'b01:   o_fifo_count <= o_fifo_count - 1'b1;
            default: o_fifo_count <= o_fifo_count;
         endcase
      end
   end

   // Storage needs no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= rx_shift;
   end

   assign o_tx_busy = (tx_state != TX_IDLE);

endmodule
